// File: rtl/sm_cpu_pkg.sv
// sm_cpu_pkg: shared definitions for the schoolRISCV core slice.
//   SM_PC_W       - program counter width (bits)
//   SM_INSTR_W    - instruction width (bits)
//   SM_ILEN_BYTES - instruction length in bytes (PC step)
//   fetch_entry_t - {pc, instr} pair carried from fetch to decode
//   sat_add32     - 32-bit add that clamps at all-ones instead of wrapping
package sm_cpu_pkg;

  localparam int SM_PC_W       = 32;
  localparam int SM_INSTR_W    = 32;
  localparam int SM_ILEN_BYTES = 4;

  typedef struct packed {
    logic [SM_PC_W-1:0]    pc;
    logic [SM_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/sm_ifetch_fifo.sv
// sm_ifetch_fifo: small synchronous prefetch FIFO of fetch entries.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   push, wdata    - write wdata at tail (accepted when not full, or when
//                    a pop frees a slot at the same edge)
//   pop            - drop the head entry (ignored when empty)
//   flush          - empty the FIFO and zero the pointers; beats push/pop
//   rdata          - head entry (combinational from storage)
//   count          - number of entries held
//   full, empty    - occupancy flags
// DEPTH must be a power of two so pointers wrap naturally.
module sm_ifetch_fifo
  import sm_cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  fetch_entry_t     mem_reg [DEPTH];

  logic do_push;
  logic do_pop;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign rdata = mem_reg[rd_ptr_reg];

  // A pop at the same edge frees the slot the push is about to take.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

endmodule

// File: rtl/sm_ifetch.sv
// sm_ifetch: instruction fetch front end for one schoolRISCV core.
// Owns the fetch PC, addresses the word-indexed instruction ROM, buffers
// returned words in a prefetch FIFO and presents {pc, instr} to decode.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   im_addr   (out, 32)   - ROM word address = fetch_pc >> 2
//   im_data   (in,  32)   - ROM word for im_addr, same cycle
//   instr_valid (out)     - FIFO head holds an instruction
//   instr_ready (in)      - decode takes the head this cycle
//   instr, instr_pc (out) - head instruction / byte PC, zero when not valid
//   redirect, redirect_pc - flush FIFO and restart fetch at redirect_pc
// Optional (macro SM_IFETCH_PERF_EN):
//   perf_fetched (out,32) - saturating count of pushes
//   perf_flushed (out,32) - saturating count of entries discarded by redirects
module sm_ifetch
  import sm_cpu_pkg::*;
#(
  parameter int                 DEPTH    = 2,
  parameter logic [SM_PC_W-1:0] RESET_PC = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [SM_PC_W-1:0]    im_addr,
  input  logic [SM_INSTR_W-1:0] im_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [SM_INSTR_W-1:0] instr,
  output logic [SM_PC_W-1:0]    instr_pc,
  input  logic                  redirect,
`ifdef SM_IFETCH_PERF_EN
  input  logic [SM_PC_W-1:0]    redirect_pc,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed
`else
  input  logic [SM_PC_W-1:0]    redirect_pc
`endif
);

  logic [SM_PC_W-1:0]   fetch_pc_reg;
  logic [SM_PC_W-1:0]   fetch_pc_next;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  fetch_entry_t         fifo_wdata;
  fetch_entry_t         fifo_head;

  // Low byte-offset bits of the target are deliberately dropped.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign im_addr = {2'b00, fetch_pc_reg[SM_PC_W-1:2]};

  assign pop  = instr_valid & instr_ready;
  assign push = (~fifo_full | pop) & ~redirect;

  assign fifo_wdata.pc    = fetch_pc_reg;
  assign fifo_wdata.instr = im_data;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect)
      fetch_pc_next = {redirect_pc[SM_PC_W-1:2], 2'b00};
    else if (push)
      fetch_pc_next = fetch_pc_reg + SM_PC_W'(SM_ILEN_BYTES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_pc_reg <= RESET_PC;
    else        fetch_pc_reg <= fetch_pc_next;
  end

  // Redirect doubles as the FIFO flush, so it also cancels any pop/push.
  sm_ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .flush (redirect),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign instr_valid = ~fifo_empty;
  assign instr       = instr_valid ? fifo_head.instr : '0;
  assign instr_pc    = instr_valid ? fifo_head.pc    : '0;

`ifdef SM_IFETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_flushed_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_reg <= '0;
      perf_flushed_reg <= '0;
    end else begin
      if (push)
        perf_fetched_reg <= sat_add32(perf_fetched_reg, 32'd1);
      if (redirect)
        perf_flushed_reg <= sat_add32(perf_flushed_reg, 32'(fifo_count));
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_flushed = perf_flushed_reg;
`else
  logic unused_count;
  assign unused_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_sm_ifetch.sv
// tb_sm_ifetch: directed self-checking bench for sm_ifetch.
// dut0 uses RESET_PC=0, dut1 uses RESET_PC=32'hFFFFFFF8 (PC wrap). Both
// share clock, reset and control inputs; each has its own ROM model where
// word k reads 32'h1000 + k. Inputs change and outputs are sampled 1 time
// unit after the rising edge.
`timescale 1ns/1ps
module tb_sm_ifetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] im_addr0, im_data0, instr0, instr_pc0;
  logic        instr_valid0;
  logic [31:0] im_addr1, im_data1, instr1, instr_pc1;
  logic        instr_valid1;
`ifdef SM_IFETCH_PERF_EN
  logic [31:0] perf_fetched0, perf_flushed0, perf_fetched1, perf_flushed1;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign im_data0 = 32'h1000 + im_addr0;
  assign im_data1 = 32'h1000 + im_addr1;

  sm_ifetch #(.DEPTH(2), .RESET_PC(32'h0)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_addr     (im_addr0),
    .im_data     (im_data0),
    .instr_valid (instr_valid0),
    .instr_ready (instr_ready),
    .instr       (instr0),
    .instr_pc    (instr_pc0),
    .redirect    (redirect),
`ifdef SM_IFETCH_PERF_EN
    .redirect_pc (redirect_pc),
    .perf_fetched(perf_fetched0),
    .perf_flushed(perf_flushed0)
`else
    .redirect_pc (redirect_pc)
`endif
  );

  sm_ifetch #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_addr     (im_addr1),
    .im_data     (im_data1),
    .instr_valid (instr_valid1),
    .instr_ready (instr_ready),
    .instr       (instr1),
    .instr_pc    (instr_pc1),
    .redirect    (redirect),
`ifdef SM_IFETCH_PERF_EN
    .redirect_pc (redirect_pc),
    .perf_fetched(perf_fetched1),
    .perf_flushed(perf_flushed1)
`else
    .redirect_pc (redirect_pc)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across an edge, then release between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    instr_ready = 1'b0;
    rst_n = 1'b0;
    step();
    total++;
    if (instr_valid0 !== 1'b0 || instr0 !== 32'h0 || instr_pc0 !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b instr=%h pc=%h, want 0/0/0", instr_valid0, instr0, instr_pc0);
    end else $display("reset_outputs ok");
    total++;
    if (im_addr0 !== 32'h0 || im_addr1 !== 32'h3FFF_FFFE) begin
      bad++;
      $display("FAIL reset_im_addr: got %h/%h, want 00000000/3ffffffe", im_addr0, im_addr1);
    end else $display("reset_im_addr ok");
`ifdef SM_IFETCH_PERF_EN
    total++;
    if (perf_fetched0 !== 32'h0 || perf_flushed0 !== 32'h0) begin
      bad++;
      $display("FAIL reset_perf: fetched=%0d flushed=%0d, want 0/0", perf_fetched0, perf_flushed0);
    end else $display("reset_perf ok");
`endif
    rst_n = 1'b1;
    step();
    total++;
    if (instr_valid0 !== 1'b1 || instr_pc0 !== 32'h0 || instr0 !== 32'h1000 || im_addr0 !== 32'h1) begin
      bad++;
      $display("FAIL first_fetch: valid=%b pc=%h instr=%h addr=%h, want 1/0/1000/1",
               instr_valid0, instr_pc0, instr0, im_addr0);
    end else $display("first_fetch ok");
`ifdef SM_IFETCH_PERF_EN
    total++;
    if (perf_fetched0 !== 32'd1) begin
      bad++;
      $display("FAIL perf_fetched_first: got %0d want 1", perf_fetched0);
    end else $display("perf_fetched_first ok");
`endif
  endtask

  task automatic test_stream();
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (instr_valid0 !== 1'b1 || instr_pc0 !== 32'(4 * k) || instr0 !== 32'(32'h1000 + k)) begin
        bad++;
        $display("FAIL stream_%0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                 k, instr_valid0, instr_pc0, instr0, 4 * k, 32'h1000 + k);
      end else $display("stream_%0d pc=%h instr=%h ok", k, instr_pc0, instr0);
    end
  endtask

  // Stall with ready low, then release: full FIFO pushes and pops at the
  // same edge, so im_addr keeps advancing one word per cycle.
  task automatic test_stall_release();
    do_reset();
    instr_ready = 1'b0;
    for (int c = 0; c < 5; c++) step();
    total++;
    if (im_addr0 !== 32'd2 || instr_valid0 !== 1'b1 || instr_pc0 !== 32'h0 || instr0 !== 32'h1000) begin
      bad++;
      $display("FAIL stall_hold: addr=%h valid=%b pc=%h instr=%h, want 2/1/0/1000",
               im_addr0, instr_valid0, instr_pc0, instr0);
    end else $display("stall_hold ok");
    instr_ready = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      total++;
      if (instr_valid0 !== 1'b1 || instr_pc0 !== 32'(4 * n) || instr0 !== 32'(32'h1000 + n)
          || im_addr0 !== 32'(2 + n)) begin
        bad++;
        $display("FAIL release_%0d: valid=%b pc=%h instr=%h addr=%h, want 1/%h/%h/%h",
                 n, instr_valid0, instr_pc0, instr0, im_addr0, 4 * n, 32'h1000 + n, 2 + n);
      end else $display("release_%0d pc=%h addr=%h ok", n, instr_pc0, im_addr0);
    end
  endtask

  // Continues from a full FIFO with instr_ready=1.
  task automatic test_redirect();
    redirect = 1'b1;
    redirect_pc = 32'h42;
    step();
    total++;
    if (instr_valid0 !== 1'b0 || instr0 !== 32'h0 || instr_pc0 !== 32'h0 || im_addr0 !== 32'd16) begin
      bad++;
      $display("FAIL redirect_flush: valid=%b instr=%h pc=%h addr=%h, want 0/0/0/10",
               instr_valid0, instr0, instr_pc0, im_addr0);
    end else $display("redirect_flush ok");
`ifdef SM_IFETCH_PERF_EN
    total++;
    if (perf_flushed0 !== 32'd2) begin
      bad++;
      $display("FAIL perf_flushed: got %0d want 2", perf_flushed0);
    end else $display("perf_flushed ok");
`endif
    redirect = 1'b0;
    step();
    total++;
    if (instr_valid0 !== 1'b1 || instr_pc0 !== 32'h40 || instr0 !== 32'h1010) begin
      bad++;
      $display("FAIL redirect_target: valid=%b pc=%h instr=%h, want 1/40/1010",
               instr_valid0, instr_pc0, instr0);
    end else $display("redirect_target ok");
    step();
    total++;
    if (instr_pc0 !== 32'h44 || instr0 !== 32'h1011) begin
      bad++;
      $display("FAIL redirect_next: pc=%h instr=%h, want 44/1011", instr_pc0, instr0);
    end else $display("redirect_next ok");
  endtask

  task automatic test_redirect_held();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h207;
    step();
    total++;
    if (instr_valid0 !== 1'b0 || im_addr0 !== 32'h81) begin
      bad++;
      $display("FAIL redirect_held: valid=%b addr=%h, want 0/81", instr_valid0, im_addr0);
    end else $display("redirect_held ok");
    redirect = 1'b0;
    step();
    total++;
    if (instr_valid0 !== 1'b1 || instr_pc0 !== 32'h204 || instr0 !== 32'h1081) begin
      bad++;
      $display("FAIL redirect_held_target: valid=%b pc=%h instr=%h, want 1/204/1081",
               instr_valid0, instr_pc0, instr0);
    end else $display("redirect_held_target ok");
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_in[0] = 32'h4000_0FFE;
    exp_pc[1] = 32'hFFFF_FFFC; exp_in[1] = 32'h4000_0FFF;
    exp_pc[2] = 32'h0000_0000; exp_in[2] = 32'h0000_1000;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (instr_valid1 !== 1'b1 || instr_pc1 !== exp_pc[k] || instr1 !== exp_in[k]) begin
        bad++;
        $display("FAIL wrap_%0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                 k, instr_valid1, instr_pc1, instr1, exp_pc[k], exp_in[k]);
      end else $display("wrap_%0d pc=%h ok", k, instr_pc1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    instr_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (instr_valid0 !== 1'b0 || instr0 !== 32'h0 || instr_pc0 !== 32'h0 || im_addr0 !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: valid=%b instr=%h pc=%h addr=%h, want all 0",
               instr_valid0, instr0, instr_pc0, im_addr0);
    end else $display("async_reset ok");
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (instr_valid0 !== 1'b1 || instr_pc0 !== 32'h0 || instr0 !== 32'h1000) begin
      bad++;
      $display("FAIL async_resume: valid=%b pc=%h instr=%h, want 1/0/1000",
               instr_valid0, instr_pc0, instr0);
    end else $display("async_resume ok");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_release();
    test_redirect();
    test_redirect_held();
    test_pc_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
